// File: rtl/priority_arbiter_fsm.sv
// Four-way fixed-priority arbiter FSM (w[3] highest) with a hold limit.
// Ports: clk, rst (async, active high), w[3:0] requests, g[3:0] one-hot
// grant, Z[2:0] owner code, busy, timeout (one-cycle limit pulse).
// Optional macro ARB_FAIRNESS_EN: masks a timed-out owner for one arbitration.
module priority_arbiter_fsm #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] w,
    output logic [3:0] g,
    output logic [2:0] Z,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        RELEASE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       mask;
    logic [3:0]       req_m;
    logic [3:0]       req;
    logic [3:0]       win;

    function automatic logic [3:0] pick(input logic [3:0] r);
        logic [3:0] p;
        p = 4'b0000;
        if (r[3])      p = 4'b1000;
        else if (r[2]) p = 4'b0100;
        else if (r[1]) p = 4'b0010;
        else if (r[0]) p = 4'b0001;
        return p;
    endfunction

    // Same code the datapath decodes: w3..w0 -> 100/011/010/001.
    function automatic logic [2:0] encode(input logic [3:0] o);
        logic [2:0] c;
        c = 3'b000;
        if (o[3])      c = 3'b100;
        else if (o[2]) c = 3'b011;
        else if (o[1]) c = 3'b010;
        else if (o[0]) c = 3'b001;
        return c;
    endfunction

    // A masked requester still wins when it is the only one asking.
    always_comb begin
        req_m = w & ~mask;
        req   = (req_m != 4'b0000) ? req_m : w;
        win   = pick(req);
    end

`ifndef ARB_FAIRNESS_EN
    assign mask = 4'b0000;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            g       <= 4'b0000;
            Z       <= 3'b000;
            busy    <= 1'b0;
            timeout <= 1'b0;
            cnt     <= '0;
`ifdef ARB_FAIRNESS_EN
            mask    <= 4'b0000;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    cnt     <= '0;
                    if (w != 4'b0000) begin
                        state <= GRANT;
                        g     <= win;
                        Z     <= encode(win);
                        busy  <= 1'b1;
`ifdef ARB_FAIRNESS_EN
                        mask  <= 4'b0000;
`endif
                    end else begin
                        g    <= 4'b0000;
                        Z    <= 3'b000;
                        busy <= 1'b0;
                    end
                end
                GRANT: begin
                    // A dropped request wins over a simultaneous limit hit.
                    if ((w & g) == 4'b0000) begin
                        state   <= RELEASE;
                        g       <= 4'b0000;
                        Z       <= 3'b000;
                        busy    <= 1'b1;
                        timeout <= 1'b0;
                    end else if (cnt == LAST) begin
                        state   <= RELEASE;
                        g       <= 4'b0000;
                        Z       <= 3'b000;
                        busy    <= 1'b1;
                        timeout <= 1'b1;
`ifdef ARB_FAIRNESS_EN
                        mask    <= g;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    state   <= IDLE;
                    g       <= 4'b0000;
                    Z       <= 3'b000;
                    busy    <= 1'b0;
                    timeout <= 1'b0;
                    cnt     <= '0;
                end
                default: begin
                    state   <= IDLE;
                    g       <= 4'b0000;
                    Z       <= 3'b000;
                    busy    <= 1'b0;
                    timeout <= 1'b0;
                    cnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_priority_arbiter_fsm.sv
// Scoreboard bench for priority_arbiter_fsm with hand-computed vectors.
// Expected outputs are queued per edge and checked by a negedge monitor.
module tb_priority_arbiter_fsm;

    typedef struct {
        logic [3:0] g;
        logic [2:0] z;
        logic       busy;
        logic       to;
        string      name;
    } exp_t;

`ifdef ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] w   = 4'b0000;
    logic [3:0] g;
    logic [2:0] Z;
    logic       busy;
    logic       timeout;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    priority_arbiter_fsm #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .w       (w),
        .g       (g),
        .Z       (Z),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            if (g !== e.g || Z !== e.z || busy !== e.busy ||
                timeout !== e.to) begin
                n_fail++;
                $display("FAIL %s: got g=%b Z=%b busy=%b to=%b, want g=%b Z=%b busy=%b to=%b",
                         e.name, g, Z, busy, timeout,
                         e.g, e.z, e.busy, e.to);
            end
        end
    end

    task automatic push(input logic [3:0] eg, input logic [2:0] ez,
                        input logic eb, input logic et, input string nm);
        exp_t e;
        e.g = eg; e.z = ez; e.busy = eb; e.to = et; e.name = nm;
        exp_q.push_back(e);
    endtask

    // Drive w before an edge; queue the outputs expected after that edge.
    task automatic step(input logic [3:0] wv, input logic [3:0] eg,
                        input logic [2:0] ez, input logic eb,
                        input logic et, input string nm);
        @(negedge clk);
        w = wv;
        @(posedge clk);
        #1;
        push(eg, ez, eb, et, nm);
    endtask

    initial begin
        // reset state
        rst = 1'b1;
        @(posedge clk);
        #1;
        push(4'b0000, 3'b000, 1'b0, 1'b0, "reset");
        @(negedge clk);
        rst = 1'b0;

        // 1: w=0110 -> w2 granted, held while requested
        step(4'b0110, 4'b0100, 3'b011, 1'b1, 1'b0, "t1_grant");
        step(4'b0110, 4'b0100, 3'b011, 1'b1, 1'b0, "t1_hold");
        step(4'b0110, 4'b0100, 3'b011, 1'b1, 1'b0, "t1_hold2");
        step(4'b0000, 4'b0000, 3'b000, 1'b1, 1'b0, "t1_release");
        step(4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0, "t1_idle");

        // 2: no preemption, then w3 after RELEASE+IDLE
        step(4'b0001, 4'b0001, 3'b001, 1'b1, 1'b0, "t2_grant0");
        step(4'b1001, 4'b0001, 3'b001, 1'b1, 1'b0, "t2_nopreempt");
        step(4'b1001, 4'b0001, 3'b001, 1'b1, 1'b0, "t2_nopreempt2");
        step(4'b1000, 4'b0000, 3'b000, 1'b1, 1'b0, "t2_release");
        step(4'b1000, 4'b0000, 3'b000, 1'b0, 1'b0, "t2_idle");
        step(4'b1000, 4'b1000, 3'b100, 1'b1, 1'b0, "t2_grant3");
        step(4'b0000, 4'b0000, 3'b000, 1'b1, 1'b0, "t2_release2");
        step(4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0, "t2_idle2");

        // 3: w3 hits the hold limit with w2 also pending
        step(4'b1000, 4'b1000, 3'b100, 1'b1, 1'b0, "t3_grant");
        for (int i = 0; i < 7; i++)
            step(4'b1000, 4'b1000, 3'b100, 1'b1, 1'b0, "t3_hold");
        step(4'b1100, 4'b0000, 3'b000, 1'b1, 1'b1, "t3_timeout");
        step(4'b1100, 4'b0000, 3'b000, 1'b0, 1'b0, "t3_idle");
        step(4'b1100, FAIR ? 4'b0100 : 4'b1000, FAIR ? 3'b011 : 3'b100,
             1'b1, 1'b0, "t3_regrant");
        step(4'b0000, 4'b0000, 3'b000, 1'b1, 1'b0, "t3_release");
        step(4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0, "t3_idle2");

        // 4: sole requester regains the grant after its timeout
        step(4'b1000, 4'b1000, 3'b100, 1'b1, 1'b0, "t4_grant");
        for (int i = 0; i < 7; i++)
            step(4'b1000, 4'b1000, 3'b100, 1'b1, 1'b0, "t4_hold");
        step(4'b1000, 4'b0000, 3'b000, 1'b1, 1'b1, "t4_timeout");
        step(4'b1000, 4'b0000, 3'b000, 1'b0, 1'b0, "t4_idle");
        step(4'b1000, 4'b1000, 3'b100, 1'b1, 1'b0, "t4_regrant");
        step(4'b1000, 4'b1000, 3'b100, 1'b1, 1'b0, "t4_hold2");

        // 5: async reset between edges, mid-grant
        @(posedge clk);
        #2;
        rst = 1'b1;
        w   = 4'b0010;
        #1;
        push(4'b0000, 3'b000, 1'b0, 1'b0, "t5_async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        push(4'b0010, 3'b010, 1'b1, 1'b0, "t5_regrant");
        step(4'b0000, 4'b0000, 3'b000, 1'b1, 1'b0, "t5_release");
        step(4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0, "t5_idle");

        // 6: drop on the limit edge -> no timeout
        step(4'b0001, 4'b0001, 3'b001, 1'b1, 1'b0, "t6_grant");
        for (int i = 0; i < 7; i++)
            step(4'b0001, 4'b0001, 3'b001, 1'b1, 1'b0, "t6_hold");
        step(4'b0000, 4'b0000, 3'b000, 1'b1, 1'b0, "t6_drop_at_limit");
        step(4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0, "t6_idle");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, want 0",
                     exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
